// File: rtl/demux_1to2_stream_if.sv
// Handshake bundle for the 1:2 stream demultiplexer: one input stream
// (data + destination select) and two independent output streams.
interface demux_1to2_stream_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] in_data;
  logic             in_sel;
  logic             in_valid;
  logic             in_ready;

  logic [WIDTH-1:0] out0_data;
  logic             out0_valid;
  logic             out0_ready;

  logic [WIDTH-1:0] out1_data;
  logic             out1_valid;
  logic             out1_ready;

  // Environment side: producer on the input, consumers on both outputs.
  modport master (
    output in_data, in_sel, in_valid, out0_ready, out1_ready,
    input  in_ready, out0_data, out0_valid, out1_data, out1_valid
  );

  // Demultiplexer side.
  modport slave (
    input  in_data, in_sel, in_valid, out0_ready, out1_ready,
    output in_ready, out0_data, out0_valid, out1_data, out1_valid
  );
endinterface

// File: rtl/demux_1to2_stream.sv
// Registered 1:2 stream demultiplexer. Each output owns a one-entry holding
// register, so a stalled consumer only blocks words addressed to it. A
// per-output counter tallies completed output handshakes (wrapping).
module demux_1to2_stream #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  demux_1to2_stream_if.slave   st,
  output logic [CNT_W-1:0]     cnt0,
  output logic [CNT_W-1:0]     cnt1
);

  logic [1:0]       full_q;
  logic [WIDTH-1:0] data_q [2];
  logic [CNT_W-1:0] cnt_q  [2];

  logic [1:0]       drain;
  logic [1:0]       load;
  logic             accept;

  // Handshake decode: drains per output, input readiness from the selected
  // output only (never from in_valid), and the load strobes.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no latch can be inferred.
    drain       = '0;
    load        = '0;
    accept      = 1'b0;
    st.in_ready = 1'b0;

    drain[0]    = full_q[0] & st.out0_ready;
    drain[1]    = full_q[1] & st.out1_ready;
    // The selected slot can take a word if it is empty or is being emptied
    // this cycle. Held high during reset, when nothing is buffered anyway.
    st.in_ready = rst | ~full_q[st.in_sel] | drain[st.in_sel];
    // Reset wins: a handshake in the reset cycle never loads.
    accept      = st.in_valid & st.in_ready & ~rst;
    load[0]     = accept & ~st.in_sel;
    load[1]     = accept &  st.in_sel;
  end

  // Holding registers and counters: load beats drain on the same slot, so a
  // simultaneous drain and load keeps the slot full with the new word.
  always_ff @(posedge clk) begin
    if (rst) begin
      full_q <= '0;
      for (int k = 0; k < 2; k++) begin
        // NOTE: the data registers are cleared too, because their (possibly stale) contents are always visible on outk_data.
        data_q[k] <= '0;
        cnt_q[k]  <= '0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        // NOTE: non-blocking assignments keep every register update based on pre-edge values.
        if (load[k]) begin
          data_q[k] <= st.in_data;
          full_q[k] <= 1'b1;
        end else if (drain[k]) begin
          full_q[k] <= 1'b0;
        end
        if (drain[k]) begin
          cnt_q[k] <= cnt_q[k] + 1'b1;
        end
      end
    end
  end

  assign st.out0_valid = full_q[0];
  assign st.out0_data  = data_q[0];
  assign st.out1_valid = full_q[1];
  assign st.out1_data  = data_q[1];
  assign cnt0          = cnt_q[0];
  assign cnt1          = cnt_q[1];

endmodule

// File: tb/tb_demux_1to2_stream.sv
// Self-checking bench for demux_1to2_stream: directed scenarios followed by
// randomized traffic, all compared against a queue-based reference model.
module tb_demux_1to2_stream;

  localparam int WIDTH = 8;
  localparam int CNT_W = 4;

  logic clk = 1'b0;
  logic rst;
  logic [CNT_W-1:0] cnt0, cnt1;

  always #5 clk = ~clk;

  demux_1to2_stream_if #(.WIDTH(WIDTH)) bus ();

  demux_1to2_stream #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk  (clk),
    .rst  (rst),
    .st   (bus),
    .cnt0 (cnt0),
    .cnt1 (cnt1)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: each output is a queue of at most one word; counters are
  // plain integers reduced modulo 2^CNT_W; last[] keeps the stale data value.
  logic [WIDTH-1:0] q0[$], q1[$];
  logic [WIDTH-1:0] log0[$], log1[$];
  logic [WIDTH-1:0] last0, last1;
  int               m_cnt0, m_cnt1;
  bit               model_valid = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: compare DUT against the model at the falling edge, apply
  // the spec rules to the model, then wait past the rising edge.
  task automatic cycle();
    bit exp_ready, d0, d1, acc;
    @(negedge clk);
    if (rst)
      exp_ready = 1'b1;
    else if (bus.in_sel)
      exp_ready = (q1.size() == 0) || bus.out1_ready;
    else
      exp_ready = (q0.size() == 0) || bus.out0_ready;

    if (model_valid) begin
      check("in_ready",   32'(bus.in_ready),   32'(exp_ready));
      check("out0_valid", 32'(bus.out0_valid), 32'(q0.size() != 0));
      check("out1_valid", 32'(bus.out1_valid), 32'(q1.size() != 0));
      check("out0_data",  32'(bus.out0_data),  32'((q0.size() != 0) ? q0[0] : last0));
      check("out1_data",  32'(bus.out1_data),  32'((q1.size() != 0) ? q1[0] : last1));
      check("cnt0",       32'(cnt0),           32'(m_cnt0));
      check("cnt1",       32'(cnt1),           32'(m_cnt1));
    end

    if (rst) begin
      q0.delete(); q1.delete();
      last0 = '0; last1 = '0;
      m_cnt0 = 0; m_cnt1 = 0;
      model_valid = 1'b1;
    end else begin
      d0  = (q0.size() != 0) && bus.out0_ready;
      d1  = (q1.size() != 0) && bus.out1_ready;
      acc = bus.in_valid && exp_ready;
      if (d0) begin log0.push_back(q0.pop_front()); m_cnt0 = (m_cnt0 + 1) % (1 << CNT_W); end
      if (d1) begin log1.push_back(q1.pop_front()); m_cnt1 = (m_cnt1 + 1) % (1 << CNT_W); end
      if (acc) begin
        if (bus.in_sel) begin q1.push_back(bus.in_data); last1 = bus.in_data; end
        else            begin q0.push_back(bus.in_data); last0 = bus.in_data; end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit v, input bit sel, input logic [WIDTH-1:0] d);
    bus.in_valid = v;
    bus.in_sel   = sel;
    bus.in_data  = d;
  endtask

  initial begin
    logic [CNT_W-1:0] base;
    rst = 1'b1;
    drive(1'b0, 1'b0, '0);
    bus.out0_ready = 1'b1;
    bus.out1_ready = 1'b1;

    // Reset then idle.
    cycle();
    cycle();
    check("rst_in_ready",   32'(bus.in_ready),   32'd1);
    check("rst_out0_valid", 32'(bus.out0_valid), 32'd0);
    check("rst_out1_valid", 32'(bus.out1_valid), 32'd0);
    check("rst_out0_data",  32'(bus.out0_data),  32'd0);
    check("rst_out1_data",  32'(bus.out1_data),  32'd0);
    check("rst_cnt0",       32'(cnt0),           32'd0);
    check("rst_cnt1",       32'(cnt1),           32'd0);
    rst = 1'b0;
    cycle();

    // Basic routing.
    drive(1'b1, 1'b0, 8'hA5);
    cycle();
    check("route_out0_valid", 32'(bus.out0_valid), 32'd1);
    check("route_out0_data",  32'(bus.out0_data),  32'hA5);
    drive(1'b1, 1'b1, 8'h3C);
    cycle();
    check("route_out1_valid", 32'(bus.out1_valid), 32'd1);
    check("route_out1_data",  32'(bus.out1_data),  32'h3C);
    drive(1'b0, 1'b0, '0);
    cycle();
    check("route_cnt0", 32'(cnt0), 32'd1);
    check("route_cnt1", 32'(cnt1), 32'd1);

    // Backpressure isolation.
    base = cnt0;
    log0.delete(); log1.delete();
    bus.out0_ready = 1'b0;
    drive(1'b1, 1'b0, 8'h11);
    cycle();
    drive(1'b1, 1'b0, 8'h22);
    #1;
    check("bp_stall_ready", 32'(bus.in_ready), 32'd0);
    cycle();
    cycle();
    check("bp_hold_data", 32'(bus.out0_data), 32'h11);
    drive(1'b1, 1'b1, 8'h33);
    #1;
    check("bp_other_ready", 32'(bus.in_ready), 32'd1);
    cycle();
    check("bp_out1_data", 32'(bus.out1_data), 32'h33);
    check("bp_out0_still", 32'(bus.out0_data), 32'h11);
    bus.out0_ready = 1'b1;
    drive(1'b1, 1'b0, 8'h22);
    cycle();
    drive(1'b0, 1'b0, '0);
    cycle();
    cycle();
    check("bp_cnt0", 32'(cnt0), 32'(CNT_W'(base + 2)));
    check("bp_order_len", 32'(log0.size()), 32'd2);
    if (log0.size() == 2) begin
      check("bp_order_0", 32'(log0[0]), 32'h11);
      check("bp_order_1", 32'(log0[1]), 32'h22);
    end

    // Full-rate streaming, alternating destinations.
    log0.delete(); log1.delete();
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, i[0], WIDTH'(i));
      #1;
      check("stream_ready", 32'(bus.in_ready), 32'd1);
      cycle();
    end
    drive(1'b0, 1'b0, '0);
    cycle();
    cycle();
    check("stream_len0", 32'(log0.size()), 32'd8);
    check("stream_len1", 32'(log1.size()), 32'd8);
    for (int i = 0; i < 8; i++) begin
      if (i < log0.size()) check("stream_word0", 32'(log0[i]), 32'(2 * i));
      if (i < log1.size()) check("stream_word1", 32'(log1[i]), 32'(2 * i + 1));
    end

    // Simultaneous drain and load on out1.
    bus.out1_ready = 1'b0;
    drive(1'b1, 1'b1, 8'h7E);
    cycle();
    drive(1'b0, 1'b0, '0);
    cycle();
    base = cnt1;
    bus.out1_ready = 1'b1;
    drive(1'b1, 1'b1, 8'h81);
    #1;
    check("sim_ready", 32'(bus.in_ready), 32'd1);
    cycle();
    check("sim_valid", 32'(bus.out1_valid), 32'd1);
    check("sim_data",  32'(bus.out1_data),  32'h81);
    check("sim_cnt1",  32'(cnt1),           32'(CNT_W'(base + 1)));
    drive(1'b0, 1'b0, '0);
    cycle();

    // Counter wrap then reset while out0 is full.
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    bus.out0_ready = 1'b1;
    for (int i = 0; i < 17; i++) begin
      drive(1'b1, 1'b0, WIDTH'(8'h40 + i));
      cycle();
      // After cycle i, i words have drained.
      if (i == 15) check("wrap_cnt_15", 32'(cnt0), 32'hF);
      if (i == 16) check("wrap_cnt_16", 32'(cnt0), 32'h0);
    end
    drive(1'b1, 1'b0, 8'h99);
    cycle();
    check("wrap_cnt_17", 32'(cnt0), 32'h1);
    check("wrap_full",   32'(bus.out0_valid), 32'd1);
    rst = 1'b1;
    drive(1'b1, 1'b0, 8'h5A);
    cycle();
    check("mrst_cnt0",  32'(cnt0),           32'd0);
    check("mrst_valid", 32'(bus.out0_valid), 32'd0);
    check("mrst_data",  32'(bus.out0_data),  32'd0);
    check("mrst_cnt1",  32'(cnt1),           32'd0);
    rst = 1'b0;
    drive(1'b0, 1'b0, '0);
    cycle();

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 600; i++) begin
      rst            = ($urandom_range(0, 99) == 0);
      bus.in_valid   = $urandom_range(0, 3) != 0;
      bus.in_sel     = 1'($urandom);
      bus.in_data    = WIDTH'($urandom);
      bus.out0_ready = $urandom_range(0, 2) != 0;
      bus.out1_ready = $urandom_range(0, 3) == 0;
      cycle();
    end
    rst = 1'b0;
    drive(1'b0, 1'b0, '0);
    bus.out0_ready = 1'b1;
    bus.out1_ready = 1'b1;
    cycle();
    cycle();
    check("final_empty0", 32'(bus.out0_valid), 32'd0);
    check("final_empty1", 32'(bus.out1_valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/demux_1to2_stream.md
# demux_1to2_stream

Registered 1:2 stream demultiplexer with valid/ready handshakes: routes each word on a single input stream to one of two output streams, chosen per word by a select bit. It is the distributing counterpart of the 2:1 mux in the elements catalog and sits wherever one producer feeds two consumers, such as splitting a result bus between two functional units. Each output has its own one-entry holding register, so a stalled consumer never blocks words bound for the other output. Per-output transfer counters support bring-up and verification.

## Interface
- WIDTH, 8, data word width in bits (≥1)
- CNT_W, 8, width of each per-output transfer counter (≥1)

- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- in_data  in  WIDTH  input word
- in_sel  in  1  destination of in_data: 0 → out0, 1 → out1
- in_valid  in  1  in_data/in_sel valid
- in_ready  out  1  block accepts the input word this cycle
- out0_data  out  WIDTH  output 0 word (holding register)
- out0_valid  out  1  output 0 register full
- out0_ready  in  1  consumer 0 accepts
- out1_data  out  WIDTH  output 1 word (holding register)
- out1_valid  out  1  output 1 register full
- out1_ready  in  1  consumer 1 accepts
- cnt0  out  CNT_W  completed out0 handshakes, wraps modulo 2^CNT_W
- cnt1  out  CNT_W  completed out1 handshakes, wraps modulo 2^CNT_W

## Operation
- Per output k: register data_k, flag full_k. outk_valid = full_k. outk_data = data_k.
- Input handshake: accept = in_valid & in_ready.
- Output handshake: drain_k = full_k & outk_ready.
- in_ready = ~full_s | drain_s, where s = in_sel. It is combinational from in_sel, full_s and outs_ready. It does not depend on in_valid.
- On accept with in_sel = s:
  - data_s ← in_data, full_s ← 1 at the next edge.
  - Simultaneous drain_s and accept: the old word leaves, the new word loads, full_s stays 1. This sustains one word per cycle per output.
- drain_k without a load into k: full_k ← 0, data_k holds its stale value.
- The non-selected output is unaffected by the input. It drains independently in the same cycle.
- Both outputs may drain in the same cycle.
- Ordering: order is preserved per output. No ordering is defined across outputs.
- No word is dropped or duplicated.
- outk_valid, once high, stays high and outk_data stays stable until drain_k. This follows AXI-style valid persistence.
- Counters: cntk increments by 1 on each drain_k. The value 2^CNT_W−1 wraps to 0. A counter is never affected by the other output or by the input.
- Inputs with in_valid = 0 are ignored regardless of in_sel/in_data. in_sel may toggle freely when in_valid = 0.

## Timing
- Reset (rst high at a clk edge):
  - full0 = full1 = 0.
  - data0 = data1 = 0.
  - cnt0 = cnt1 = 0.
  - Resulting outputs: out0_valid = out1_valid = 0, out0_data = out1_data = 0, cnt0 = cnt1 = 0.
  - in_ready = 1 while rst is high and after release.
- Reset mid-operation:
  - Buffered words are discarded.
  - Handshakes in the reset cycle do not count and do not load.
  - Reset wins over every simultaneous event.
- Latency: a word accepted at edge n appears with outk_valid = 1 immediately after edge n. That is 1 cycle input-to-output.
- Throughput: 1 word/cycle per output with the consumer ready continuously. Aggregate input throughput is limited to 1 word/cycle.
- Full/stall boundary: if full_s = 1 and outs_ready = 0, then in_ready = 0 and the input word is held by the producer.
  - A word to the other, empty output is still accepted if in_sel selects it.
- No combinational path from in_valid to in_ready. No path from in_data to any output except through the registers.

## Test plan
- Reset then idle:
  - Stimulus: rst high 2 cycles, in_valid = 0.
  - Required: both outk_valid = 0, outk_data = 0, cnt0 = cnt1 = 0, in_ready = 1.
- Basic routing:
  - Stimulus: send 0xA5 with sel 0, then 0x3C with sel 1, both consumers ready.
  - Required: out0 shows 0xA5 one cycle after accept, out1 shows 0x3C one cycle later, cnt0 = 1, cnt1 = 1.
- Backpressure isolation:
  - Stimulus: out0_ready = 0; send 0x11 (sel 0), then 0x22 (sel 0), then 0x33 (sel 1).
  - Required: 0x11 held on out0 and in_ready = 0 for the 0x22 word. 0x33 is still accepted and delivered on out1.
  - Release out0_ready: 0x11 then 0x22 delivered in order, cnt0 = 2.
- Full-rate streaming:
  - Stimulus: 16 consecutive words 0x00..0x0F alternating sel, both consumers ready.
  - Required: in_ready constantly 1, no gaps, each output receives its 8 words in order.
- Simultaneous drain and load:
  - Stimulus: out1 full with 0x7E; in the same cycle out1_ready = 1 and 0x81 is sent with sel 1.
  - Required: 0x7E counted, out1_valid stays 1 with data 0x81 next cycle.
- Counter wrap and mid-operation reset:
  - Stimulus: set CNT_W = 4; perform 17 out0 handshakes, then assert rst while out0 is full.
  - Required: cnt0 reads 0xF after 15 handshakes, 0x0 after 16 and 0x1 after 17. After rst, all state is cleared and no handshake is counted in the rst cycle.
